snn_noc_scheduler: RTL and testbench
====================================

# snn_noc_scheduler

Clocked controller that sequences one SNN convolution timestep across the 3x3 PE mesh. It holds the three 24-bit filter rows and one 5x5 input-spike frame, injects the filter and ifmap-window packets into the NoC in fixed PE order, and collects the nine membrane-potential/spike results in any order. It then streams them to the memory write port and signals timestep completion. It sits between the memory side and the NoC injection/ejection ports.

## Interface
- BL, 2: idle cycles inserted after every accepted NoC packet (0 = back-to-back).
- SRC_ADDR, 4'b1101: source address placed in every injected packet.
- TSW, 4: width of the timestep counter.

- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  begin a timestep; honoured only in IDLE.
- ifmap  in  25  spike frame, bit r*5+c = spike at (row r, col c); sampled on accepted start.
- filt_we  in  1  filter row write strobe; honoured only in IDLE.
- filt_row  in  2  filter row index 0..2 (3 ignored).
- filt_data  in  24  three 8-bit weights, [7:0] = col 0.
- noc_out_valid  out  1  injected packet valid.
- noc_out_ready  in  1  NoC accepts packet.
- noc_out_data  out  33  {type, dest[3:0], src[3:0], payload[23:0]}; type 0 = filter, 1 = ifmap.
- noc_in_valid  in  1  result packet valid.
- noc_in_ready  out  1  high only in RECV.
- noc_in_data  in  33  [27:24] = source PE address, [8] = spike, [7:0] = potential.
- wb_valid  out  1  write-back beat valid.
- wb_ready  in  1  memory accepts beat.
- wb_kind  out  1  0 = membrane potential, 1 = output spike.
- wb_x, wb_y  out  2 each  output-map row and column.
- wb_data  out  8  potential, or {7'b0, spike}.
- busy  out  1  high outside IDLE.
- step_done  out  1  one-cycle pulse at the end of WB.
- ts  out  TSW  count of completed timesteps; wraps modulo 2^TSW.
- err_dup, err_addr  out  1 each  sticky error flags; cleared only by reset.

## Operation
- PE (r,c), r,c in 0..2, has address {c[1:0], (2-r)[1:0]}. PE index p = r*3+c. Address order for p = 0..8: 0010,0110,1010,0001,0101,1001,0000,0100,1000.
- States and transitions:
  - IDLE: accepts filter writes. start=1 captures ifmap and moves to SEND.
  - SEND: completes when all 36 packets have been accepted, then moves to RECV.
  - RECV: moves to WB when the received mask reaches 9'h1FF.
  - WB: after 18 beats, pulses step_done, increments ts, and returns to IDLE.
- Injection order:
  - Filter row 0: for p = 0..8, filter packet to PE p, immediately followed by the ifmap packet to PE p.
  - Filter row 1: p = 0..8, filter packets only.
  - Filter row 2: p = 0..8, filter packets only.
  - Total 36 packets.
- Filter packet payload = filt_data of the current row.
- Ifmap packet payload = {15'b0, w[8:0]}, where w[dr*3+dc] = ifmap[(r+dr)*5+(c+dc)].
- RECV decodes [27:24] into (r,c) and stores potential and spike.
  - Column field 11 or row code 11: packet consumed and dropped, err_addr set.
  - Already-received PE: packet consumed and dropped, err_dup set, stored data and mask unchanged.
- WB order: (x,y) row-major over 0..2; for each position, the potential beat then the spike beat.
- start while busy is ignored. filt_we outside IDLE is ignored.

## Timing
- Reset values:
  - State IDLE; all outputs 0, including ts, the error flags, the mask, the stored results and the filter registers.
  - Reset mid-operation aborts immediately with no partial step_done.
- start accepted at edge n gives noc_out_valid=1 from cycle n+1.
- noc_out_valid and noc_out_data stay stable until noc_out_ready=1.
- After each handshake, noc_out_valid is low for exactly BL cycles.
- With ready tied high and BL=2, packet k (0..35) is valid during cycle n+1+3k.
- RECV is entered the cycle after the 36th handshake. noc_in_ready=1 throughout RECV; one packet per cycle.
- WB is entered the cycle after the ninth unique result. Beats are held stable until wb_ready; no BL gap.
- step_done is high in the cycle after the 18th wb handshake. busy=0 in the same cycle. ts updates in the same cycle.

## Test plan
- Filter rows 0x030201, 0x060504, 0x090807; ifmap all ones; start; ready high, BL=2 -> packet 0 = {0,4'b0010,4'b1101,24'h030201}, packet 1 = {1,4'b0010,4'b1101,24'h0001FF}, packet 35 dest 4'b1000 with payload 24'h090807, valid at start+106.
- ifmap with only bit 12 set (centre) -> ifmap payload bit 4 for PE (1,1), bit 0 for PE (2,2), bit 8 for PE (0,0).
- Nine results returned in reverse address order, PE (r,c) potential = r*3+c+10, spike = c==1 -> 18 beats (0,0):10,0 … (2,2):18,0 in row-major order; step_done once; ts=1.
- noc_out_ready toggling 1/0 every 3 cycles, and wb_ready low for 5 cycles -> data held stable, no packet or beat lost or duplicated.
- Duplicate from PE (0,0) plus a packet from address 4'b0011 during RECV -> err_dup=1, err_addr=1, mask unaffected, WB waits for all nine valid PEs.
- Reset asserted mid-SEND, then start -> busy=0 and outputs 0 immediately on reset; on the following start, sequence restarts at packet 0 with filters zeroed.

Source files
------------

// File: rtl/snn_noc_scheduler.sv
// Timestep sequencer for the 3x3 SNN PE mesh: injects filter and ifmap-window packets,
// gathers the nine PE results in any order, then streams them to the memory write port.
module snn_noc_scheduler #(
    parameter int         BL       = 2,
    parameter logic [3:0] SRC_ADDR = 4'b1101,
    parameter int         TSW      = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [24:0]    ifmap,
    input  logic           filt_we,
    input  logic [1:0]     filt_row,
    input  logic [23:0]    filt_data,
    output logic           noc_out_valid,
    input  logic           noc_out_ready,
    output logic [32:0]    noc_out_data,
    input  logic           noc_in_valid,
    output logic           noc_in_ready,
    input  logic [32:0]    noc_in_data,
    output logic           wb_valid,
    input  logic           wb_ready,
    output logic           wb_kind,
    output logic [1:0]     wb_x,
    output logic [1:0]     wb_y,
    output logic [7:0]     wb_data,
    output logic           busy,
    output logic           step_done,
    output logic [TSW-1:0] ts,
    output logic           err_dup,
    output logic           err_addr
);

    localparam int GW = (BL > 0) ? $clog2(BL + 1) : 1;

    typedef enum logic [1:0] {IDLE, SEND, RECV, WB} state_t;

    state_t          state, state_next;
    logic [23:0]     filt0, filt1, filt2;
    logic [24:0]     ifmap_q;
    logic [5:0]      pkt_idx;
    logic [GW-1:0]   gap_cnt;
    logic [8:0]      mask, mask_next;
    logic [7:0]      pot [9];
    logic [8:0]      spk;
    logic [4:0]      wb_idx;

    logic [1:0]      sel_row;
    logic [3:0]      sel_p, sel_rc, wb_rc, in_p;
    logic            sel_type;
    logic [4:0]      win_base;
    logic [8:0]      win;
    logic [23:0]     filt_sel;
    logic [1:0]      in_col, in_rc, in_r;
    logic            in_hs, in_bad, in_new, out_hs, wb_hs, wb_last, unused_in_bits;

    // Maps PE index p = r*3+c back to {r, c}.
    function automatic logic [3:0] pe_rc(input logic [3:0] p);
        case (p)
            4'd0:    pe_rc = 4'b0000;
            4'd1:    pe_rc = 4'b0001;
            4'd2:    pe_rc = 4'b0010;
            4'd3:    pe_rc = 4'b0100;
            4'd4:    pe_rc = 4'b0101;
            4'd5:    pe_rc = 4'b0110;
            4'd6:    pe_rc = 4'b1000;
            4'd7:    pe_rc = 4'b1001;
            4'd8:    pe_rc = 4'b1010;
            default: pe_rc = 4'b0000;
        endcase
    endfunction

    // Packets 0..17 interleave row-0 filter/ifmap per PE; 18..35 are rows 1 and 2.
    always_comb begin
        sel_row  = 2'd0;
        sel_p    = 4'd0;
        sel_type = 1'b0;
        if (pkt_idx < 6'd18) begin
            sel_p    = pkt_idx[4:1];
            sel_type = pkt_idx[0];
        end else if (pkt_idx < 6'd27) begin
            sel_row = 2'd1;
            sel_p   = 4'(pkt_idx - 6'd18);
        end else begin
            sel_row = 2'd2;
            sel_p   = 4'(pkt_idx - 6'd27);
        end
    end

    assign sel_rc   = pe_rc(sel_p);
    assign win_base = {3'b000, sel_rc[3:2]} * 5'd5 + {3'b000, sel_rc[1:0]};
    assign win = {ifmap_q[win_base + 5'd12], ifmap_q[win_base + 5'd11], ifmap_q[win_base + 5'd10],
                  ifmap_q[win_base + 5'd7],  ifmap_q[win_base + 5'd6],  ifmap_q[win_base + 5'd5],
                  ifmap_q[win_base + 5'd2],  ifmap_q[win_base + 5'd1],  ifmap_q[win_base]};

    always_comb begin
        case (sel_row)
            2'd1:    filt_sel = filt1;
            2'd2:    filt_sel = filt2;
            default: filt_sel = filt0;
        endcase
    end

    assign noc_out_valid = (state == SEND) && (gap_cnt == '0);
    assign noc_out_data  = noc_out_valid ?
        {sel_type, sel_rc[1:0], 2'd2 - sel_rc[3:2], SRC_ADDR, sel_type ? {15'b0, win} : filt_sel} : 33'd0;
    assign out_hs = noc_out_valid && noc_out_ready;

    // Result address {col, 2-row}; code 11 in either field names no PE.
    assign noc_in_ready   = (state == RECV);
    assign in_col         = noc_in_data[27:26];
    assign in_rc          = noc_in_data[25:24];
    assign in_r           = 2'd2 - in_rc;
    assign in_p           = {2'b00, in_r} * 4'd3 + {2'b00, in_col};
    assign in_hs          = noc_in_ready && noc_in_valid;
    assign in_bad         = (in_col == 2'd3) || (in_rc == 2'd3);
    assign in_new         = in_hs && !in_bad && !mask[in_p];
    assign unused_in_bits = ^{noc_in_data[32:28], noc_in_data[23:9]};

    always_comb begin
        mask_next = mask;
        if (in_new) mask_next[in_p] = 1'b1;
    end

    assign wb_valid = (state == WB);
    assign wb_rc    = pe_rc(wb_idx[4:1]);
    assign wb_kind  = wb_valid & wb_idx[0];
    assign wb_x     = wb_valid ? wb_rc[3:2] : 2'd0;
    assign wb_y     = wb_valid ? wb_rc[1:0] : 2'd0;
    assign wb_data  = !wb_valid ? 8'd0 : (wb_idx[0] ? {7'b0, spk[wb_idx[4:1]]} : pot[wb_idx[4:1]]);
    assign wb_hs    = wb_valid && wb_ready;
    assign wb_last  = wb_hs && (wb_idx == 5'd17);
    assign busy     = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = SEND;
            SEND: if (out_hs && pkt_idx == 6'd35) state_next = RECV;
            RECV: if (mask_next == 9'h1FF) state_next = WB;
            WB:   if (wb_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            filt0     <= '0;
            filt1     <= '0;
            filt2     <= '0;
            ifmap_q   <= '0;
            pkt_idx   <= '0;
            gap_cnt   <= '0;
            mask      <= '0;
            spk       <= '0;
            wb_idx    <= '0;
            ts        <= '0;
            step_done <= 1'b0;
            err_dup   <= 1'b0;
            err_addr  <= 1'b0;
            for (int i = 0; i < 9; i++) pot[i] <= '0;
        end else begin
            state     <= state_next;
            step_done <= wb_last;
            if (in_hs && in_bad) err_addr <= 1'b1;
            if (in_hs && !in_bad && mask[in_p]) err_dup <= 1'b1;
            case (state)
                IDLE: begin
                    if (filt_we && filt_row == 2'd0) filt0 <= filt_data;
                    if (filt_we && filt_row == 2'd1) filt1 <= filt_data;
                    if (filt_we && filt_row == 2'd2) filt2 <= filt_data;
                    if (start) begin
                        ifmap_q <= ifmap;
                        pkt_idx <= '0;
                        gap_cnt <= '0;
                        mask    <= '0;
                        wb_idx  <= '0;
                    end
                end
                SEND: begin
                    if (out_hs) begin
                        pkt_idx <= pkt_idx + 6'd1;
                        gap_cnt <= GW'(BL);
                    end else if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                RECV: begin
                    if (in_new) begin
                        mask        <= mask_next;
                        pot[in_p]   <= noc_in_data[7:0];
                        spk[in_p]   <= noc_in_data[8];
                    end
                end
                WB: begin
                    if (wb_hs) wb_idx <= wb_idx + 5'd1;
                    if (wb_last) ts <= ts + TSW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_noc_scheduler.sv
// Randomized self-checking bench for snn_noc_scheduler against a spec-level model
// of the packet stream, result collection and write-back order.
module tb_snn_noc_scheduler;

    localparam int         BL  = 2;
    localparam logic [3:0] SRC = 4'b1101;
    localparam int         TSW = 4;

    logic           clk = 1'b0;
    logic           reset, start, filt_we, noc_out_valid, noc_out_ready, noc_in_valid, noc_in_ready;
    logic           wb_valid, wb_ready, wb_kind, busy, step_done, err_dup, err_addr;
    logic [24:0]    ifmap;
    logic [1:0]     filt_row, wb_x, wb_y;
    logic [23:0]    filt_data;
    logic [32:0]    noc_out_data, noc_in_data;
    logic [7:0]     wb_data;
    logic [TSW-1:0] ts;

    snn_noc_scheduler #(.BL(BL), .SRC_ADDR(SRC), .TSW(TSW)) dut (
        .clk(clk), .reset(reset), .start(start), .ifmap(ifmap),
        .filt_we(filt_we), .filt_row(filt_row), .filt_data(filt_data),
        .noc_out_valid(noc_out_valid), .noc_out_ready(noc_out_ready), .noc_out_data(noc_out_data),
        .noc_in_valid(noc_in_valid), .noc_in_ready(noc_in_ready), .noc_in_data(noc_in_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_kind(wb_kind), .wb_x(wb_x), .wb_y(wb_y),
        .wb_data(wb_data), .busy(busy), .step_done(step_done), .ts(ts),
        .err_dup(err_dup), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    int             n_cmp = 0;
    int             n_bad = 0;
    logic [23:0]    filt_m [3];
    logic [TSW-1:0] ts_m;
    bit             dup_m, addr_m;
    logic [32:0]    exp_pkts[$];
    logic [12:0]    exp_beats[$];
    logic [32:0]    got_pkts[$];
    int             got_cyc[$];
    logic [12:0]    got_beats[$];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    function automatic logic [3:0] addrOf(input int r, input int c);
        return {2'(c), 2'(2 - r)};
    endfunction

    // Expected injection stream built straight from the row/PE ordering rules.
    function automatic void buildPackets(input logic [24:0] ifm);
        logic [8:0] w;
        exp_pkts.delete();
        for (int row = 0; row < 3; row++)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) begin
                    exp_pkts.push_back({1'b0, addrOf(r, c), SRC, filt_m[row]});
                    if (row == 0) begin
                        for (int dr = 0; dr < 3; dr++)
                            for (int dc = 0; dc < 3; dc++)
                                w[dr*3+dc] = ifm[(r+dr)*5 + c + dc];
                        exp_pkts.push_back({1'b1, addrOf(r, c), SRC, 15'b0, w});
                    end
                end
    endfunction

    task automatic writeFilter(input logic [1:0] row, input logic [23:0] data);
        @(negedge clk);
        filt_we = 1'b1; filt_row = row; filt_data = data;
        if (row != 2'd3) filt_m[row] = data;
        @(negedge clk);
        filt_we = 1'b0;
    endtask

    // rdy_mode: 0 tied high, 1 toggles every 3 cycles, 2 random.
    // res_mode: 0 random values/order, 1 reverse-address order with potential p+10, spike c==1.
    // wb_mode : 0 tied high, 1 low for the first 5 cycles, 2 random.
    task automatic applyStimulus(input logic [24:0] ifm, input int rdy_mode, input int res_mode,
                                 input int wb_mode, input bit inject, input bit timed);
        logic [7:0]  pot_m [9];
        bit          spk_m [9];
        int          order[$];
        int          rev [9] = '{2, 5, 8, 1, 4, 7, 0, 3, 6};
        logic [32:0] rq[$];
        logic [32:0] held_data;
        logic [12:0] beat, held_beat;
        bit          held, rdy;
        int          k, i, j, cyc, since, p, tmp, sw;

        buildPackets(ifm);
        for (int q = 0; q < 9; q++) begin
            pot_m[q] = (res_mode == 1) ? 8'(q + 10) : 8'($urandom);
            spk_m[q] = (res_mode == 1) ? (q % 3 == 1) : 1'($urandom);
            order.push_back(res_mode == 1 ? rev[q] : q);
        end
        if (res_mode != 1)
            for (int q = 8; q > 0; q--) begin
                sw = $urandom_range(q, 0);
                tmp = order[q]; order[q] = order[sw]; order[sw] = tmp;
            end
        if (inject)
            for (int q = 0; q < 9; q++)
                if (order[q] == 0) begin
                    order[q] = order[0]; order[0] = 0;
                end
        for (int q = 0; q < 9; q++) begin
            p = order[q];
            rq.push_back({5'($urandom), addrOf(p / 3, p % 3), 15'($urandom), spk_m[p], pot_m[p]});
            if (inject && q == 0) begin
                rq.push_back({5'd0, addrOf(0, 0), 15'd0, ~spk_m[0], ~pot_m[0]});
                rq.push_back({5'd0, 4'b0011, 15'd0, 1'b1, 8'hAA});
                rq.push_back({5'd0, 4'b1100, 15'd0, 1'b0, 8'h55});
                dup_m = 1'b1;
                addr_m = 1'b1;
            end
        end
        exp_beats.delete();
        for (int x = 0; x < 3; x++)
            for (int y = 0; y < 3; y++) begin
                exp_beats.push_back({1'b0, 2'(x), 2'(y), pot_m[x*3+y]});
                exp_beats.push_back({1'b1, 2'(x), 2'(y), 7'b0, spk_m[x*3+y]});
            end

        @(negedge clk);
        ifmap = ifm; start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        k = 0; cyc = 0; since = -1; held = 1'b0; held_data = '0;
        while (k < 36 && cyc < 3000) begin
            cyc++;
            if (held) begin
                checkOutput("out_hold_valid", noc_out_valid, 1);
                checkOutput("out_hold_data", noc_out_data, held_data);
            end
            if (since >= 0) begin
                since++;
                if (since <= BL) checkOutput("gap_low", noc_out_valid, 0);
                else begin
                    checkOutput("gap_end", noc_out_valid, 1);
                    since = -1;
                end
            end
            case (rdy_mode)
                0:       rdy = 1'b1;
                1:       rdy = (((cyc - 1) / 3) % 2) == 0;
                default: rdy = 1'($urandom);
            endcase
            noc_out_ready = rdy;
            start = 1'($urandom); filt_we = 1'($urandom); filt_row = 2'($urandom);
            filt_data = 24'($urandom); ifmap = 25'($urandom);
            if (noc_out_valid && rdy) begin
                checkOutput($sformatf("pkt%0d", k), noc_out_data, exp_pkts[k]);
                got_pkts.push_back(noc_out_data);
                got_cyc.push_back(cyc);
                if (timed) checkOutput($sformatf("pkt%0d_time", k), cyc, 1 + (BL + 1) * k);
                k++;
                since = 0;
                held = 1'b0;
            end else begin
                held = noc_out_valid;
                held_data = noc_out_data;
            end
            @(negedge clk);
        end
        if (k < 36) checkOutput("send_timeout", k, 36);
        start = 1'b0; filt_we = 1'b0; noc_out_ready = 1'b0;

        i = 0; cyc = 0;
        while (i < rq.size() && cyc < 1000) begin
            cyc++;
            checkOutput("in_ready", noc_in_ready, 1);
            checkOutput("no_wb_yet", wb_valid, 0);
            if ($urandom_range(3, 0) != 0) begin
                noc_in_valid = 1'b1; noc_in_data = rq[i]; i++;
            end else begin
                noc_in_valid = 1'b0; noc_in_data = 33'($urandom);
            end
            @(negedge clk);
        end
        if (i < rq.size()) checkOutput("recv_timeout", i, rq.size());
        noc_in_valid = 1'b0;
        checkOutput("in_ready_off", noc_in_ready, 0);
        checkOutput("err_dup", err_dup, dup_m);
        checkOutput("err_addr", err_addr, addr_m);

        j = 0; cyc = 0; held = 1'b0; held_beat = '0;
        while (j < 18 && cyc < 1000) begin
            cyc++;
            beat = {wb_kind, wb_x, wb_y, wb_data};
            if (held) checkOutput("wb_hold", {wb_valid, beat}, {1'b1, held_beat});
            checkOutput("no_done_early", step_done, 0);
            case (wb_mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc > 5);
                default: rdy = 1'($urandom);
            endcase
            wb_ready = rdy;
            if (wb_valid && rdy) begin
                checkOutput($sformatf("beat%0d", j), beat, exp_beats[j]);
                got_beats.push_back(beat);
                j++;
                held = 1'b0;
            end else begin
                held = wb_valid;
                held_beat = beat;
            end
            @(negedge clk);
        end
        if (j < 18) checkOutput("wb_timeout", j, 18);
        wb_ready = 1'b0;
        ts_m = ts_m + TSW'(1);
        checkOutput("step_done", step_done, 1);
        checkOutput("busy_after", busy, 0);
        checkOutput("ts", ts, ts_m);
        @(negedge clk);
        checkOutput("step_done_pulse", step_done, 0);
        checkOutput("idle_out_valid", noc_out_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; ifmap = '0; filt_we = 1'b0; filt_row = '0; filt_data = '0;
        noc_out_ready = 1'b0; noc_in_valid = 1'b0; noc_in_data = '0; wb_ready = 1'b0;
        for (int q = 0; q < 3; q++) filt_m[q] = '0;
        ts_m = '0; dup_m = 1'b0; addr_m = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_out_valid", noc_out_valid, 0);
        checkOutput("rst_out_data", noc_out_data, 0);
        checkOutput("rst_in_ready", noc_in_ready, 0);
        checkOutput("rst_wb", {wb_valid, wb_kind, wb_x, wb_y, wb_data}, 0);
        checkOutput("rst_flags", {step_done, err_dup, err_addr, ts}, 0);
        reset = 1'b0;

        $display("[TB] directed: known filters, all-ones ifmap, reverse-order results");
        writeFilter(2'd0, 24'h030201);
        writeFilter(2'd1, 24'h060504);
        writeFilter(2'd2, 24'h090807);
        got_pkts.delete(); got_cyc.delete(); got_beats.delete();
        applyStimulus(25'h1FFFFFF, 0, 1, 0, 1'b0, 1'b1);
        checkOutput("pkt_count", got_pkts.size(), 36);
        if (got_pkts.size() == 36) begin
            checkOutput("pkt0_const", got_pkts[0], {1'b0, 4'b0010, 4'b1101, 24'h030201});
            checkOutput("pkt1_const", got_pkts[1], {1'b1, 4'b0010, 4'b1101, 24'h0001FF});
            checkOutput("pkt35_dest", got_pkts[35][31:28], 4'b1000);
            checkOutput("pkt35_payload", got_pkts[35][23:0], 24'h090807);
            checkOutput("pkt35_cycle", got_cyc[35], 106);
        end
        checkOutput("beat_count", got_beats.size(), 18);
        if (got_beats.size() == 18) begin
            checkOutput("beat0_const", got_beats[0], {1'b0, 2'd0, 2'd0, 8'd10});
            checkOutput("beat3_const", got_beats[3], {1'b1, 2'd0, 2'd1, 8'd1});
            checkOutput("beat16_const", got_beats[16], {1'b0, 2'd2, 2'd2, 8'd18});
        end

        $display("[TB] centre-spike ifmap windows");
        got_pkts.delete();
        applyStimulus(25'h0001000, 2, 0, 2, 1'b0, 1'b0);
        if (got_pkts.size() == 36) begin
            checkOutput("win_pe11", got_pkts[9][23:0], 24'h000010);
            checkOutput("win_pe22", got_pkts[17][23:0], 24'h000001);
            checkOutput("win_pe00", got_pkts[1][23:0], 24'h000100);
        end

        $display("[TB] toggling NoC ready and stalled write-back");
        writeFilter(2'd3, 24'($urandom));
        writeFilter(2'd1, 24'($urandom));
        applyStimulus(25'($urandom), 1, 0, 1, 1'b0, 1'b0);

        $display("[TB] duplicate and bad-address results");
        applyStimulus(25'($urandom), 2, 0, 2, 1'b1, 1'b0);

        $display("[TB] random timesteps");
        for (int n = 0; n < 3; n++) begin
            writeFilter(2'($urandom_range(2, 0)), 24'($urandom));
            applyStimulus(25'($urandom), 2, 0, 2, 1'b0, 1'b0);
        end

        $display("[TB] reset during SEND");
        @(negedge clk);
        ifmap = 25'($urandom); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_out", {noc_out_valid, noc_out_data}, 0);
        checkOutput("midrst_flags", {step_done, err_dup, err_addr, ts}, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int q = 0; q < 3; q++) filt_m[q] = '0;
        ts_m = '0; dup_m = 1'b0; addr_m = 1'b0;
        got_pkts.delete();
        applyStimulus(25'($urandom), 0, 0, 0, 1'b0, 1'b1);
        if (got_pkts.size() == 36)
            checkOutput("restart_filt_zero", got_pkts[0][23:0], 24'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
